// File: rtl/joint_position_tracker.sv
// Joint position tracker: limit-clamped step counter with windowed velocity,
// stall detection and a sticky direction-conflict flag.
module joint_position_tracker #(
    parameter int                      POS_W        = 16,
    parameter logic signed [POS_W-1:0] MIN_POS      = -16'sd20000,
    parameter logic signed [POS_W-1:0] MAX_POS      = 16'sd20000,
    parameter int                      VEL_WINDOW   = 1000,
    parameter int                      STALL_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cw,
    input  logic             ccw,
    input  logic             zero,
    input  logic             load,
    input  logic [POS_W-1:0] load_val,
    output logic [POS_W-1:0] position,
    output logic [POS_W-1:0] velocity,
    output logic             vel_valid,
    output logic             at_min,
    output logic             at_max,
    output logic             limit_hit,
    output logic             dir,
    output logic             stalled,
    output logic             conflict_err
);

    localparam int WIN_W   = $clog2(VEL_WINDOW);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    localparam logic [WIN_W-1:0]       WIN_LAST  = WIN_W'(VEL_WINDOW - 1);
    localparam logic [STALL_W-1:0]     STALL_MAX = STALL_W'(STALL_CYCLES);
    localparam logic signed [POS_W:0]  ACC_MAX   = {2'b00, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W:0]  ACC_MIN   = {2'b11, {(POS_W-2){1'b0}}, 1'b1};

    logic signed [POS_W-1:0] pos_q;
    logic signed [POS_W-1:0] acc_q;
    logic [WIN_W-1:0]        win_cnt;
    logic [STALL_W-1:0]      stall_cnt;

    logic signed [POS_W-1:0] lv;
    logic signed [POS_W-1:0] load_clamped;
    logic signed [POS_W:0]   step_delta;
    logic signed [POS_W:0]   acc_sum;
    logic signed [POS_W-1:0] acc_next;
    logic step_up, step_dn, blk_up, blk_dn, acc_up, acc_dn, accepted;

    assign lv       = load_val;
    assign position = pos_q;
    assign at_min   = (pos_q == MIN_POS);
    assign at_max   = (pos_q == MAX_POS);

    // A step only competes for the position when neither zero nor load claims it.
    assign step_up  = cw & ~ccw & ~zero & ~load;
    assign step_dn  = ccw & ~cw & ~zero & ~load;
    assign blk_up   = step_up & (pos_q >= MAX_POS);
    assign blk_dn   = step_dn & (pos_q <= MIN_POS);
    assign acc_up   = step_up & ~blk_up;
    assign acc_dn   = step_dn & ~blk_dn;
    assign accepted = acc_up | acc_dn;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_clamped = lv;
        if (lv > MAX_POS)
            load_clamped = MAX_POS;
        else if (lv < MIN_POS)
            load_clamped = MIN_POS;

        step_delta = '0;
        if (acc_up)
            step_delta = (POS_W+1)'(1);
        else if (acc_dn)
            step_delta = '1;

        acc_sum  = {acc_q[POS_W-1], acc_q} + step_delta;
        acc_next = acc_sum[POS_W-1:0];
        if (acc_sum > ACC_MAX)
            acc_next = ACC_MAX[POS_W-1:0];
        else if (acc_sum < ACC_MIN)
            acc_next = ACC_MIN[POS_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // see pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q        <= '0;
            acc_q        <= '0;
            win_cnt      <= '0;
            stall_cnt    <= '0;
            velocity     <= '0;
            vel_valid    <= 1'b0;
            limit_hit    <= 1'b0;
            dir          <= 1'b1;
            stalled      <= 1'b0;
            conflict_err <= 1'b0;
        end else begin
            if (zero)
                pos_q <= '0;
            else if (load)
                pos_q <= load_clamped;
            else if (acc_up)
                pos_q <= pos_q + 1'b1;
            else if (acc_dn)
                pos_q <= pos_q - 1'b1;

            limit_hit <= blk_up | blk_dn;

            if (acc_up)
                dir <= 1'b1;
            else if (acc_dn)
                dir <= 1'b0;

            if (cw & ccw)
                conflict_err <= 1'b1;

            // The terminal cycle's own step lands in the published total.
            if (win_cnt == WIN_LAST) begin
                win_cnt   <= '0;
                velocity  <= acc_next;
                vel_valid <= 1'b1;
                acc_q     <= '0;
            end else begin
                win_cnt   <= win_cnt + 1'b1;
                vel_valid <= 1'b0;
                acc_q     <= acc_next;
            end

            if (accepted) begin
                stall_cnt <= '0;
                stalled   <= 1'b0;
            end else begin
                if (stall_cnt != STALL_MAX)
                    stall_cnt <= stall_cnt + 1'b1;
                stalled <= (stall_cnt >= STALL_MAX - 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_joint_position_tracker.sv
// Directed bench for joint_position_tracker with a 10-cycle velocity window
// and a 20-cycle stall threshold.
module tb_joint_position_tracker;

    localparam int POS_W = 16;
    localparam logic signed [15:0] MINP = -16'sd20000;
    localparam logic signed [15:0] MAXP = 16'sd20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cw = 1'b0, ccw = 1'b0, zero = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] position, velocity;
    logic        vel_valid, at_min, at_max, limit_hit, dir, stalled, conflict_err;

    int checks = 0;
    int failures = 0;

    joint_position_tracker #(
        .POS_W(POS_W), .MIN_POS(MINP), .MAX_POS(MAXP),
        .VEL_WINDOW(10), .STALL_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset), .cw(cw), .ccw(ccw), .zero(zero), .load(load),
        .load_val(load_val), .position(position), .velocity(velocity),
        .vel_valid(vel_valid), .at_min(at_min), .at_max(at_max),
        .limit_hit(limit_hit), .dir(dir), .stalled(stalled),
        .conflict_err(conflict_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge take them, then return to idle.
    task automatic cyc(input logic c, input logic cc, input logic z, input logic l,
                       input logic [15:0] lv);
        cw = c; ccw = cc; zero = z; load = l; load_val = lv;
        @(posedge clk); #1;
        cw = 1'b0; ccw = 1'b0; zero = 1'b0; load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cw = 1'b1; zero = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (position !== 16'd0) begin failures++; $display("FAIL reset_position got=%0d exp=0", $signed(position)); end
        checks++; if (velocity !== 16'd0) begin failures++; $display("FAIL reset_velocity got=%0d exp=0", $signed(velocity)); end
        checks++; if ({vel_valid, limit_hit, stalled, conflict_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {vel_valid, limit_hit, stalled, conflict_err}); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", dir); end
        checks++; if ({at_min, at_max} !== 2'b00) begin failures++; $display("FAIL reset_limits got=%b exp=00", {at_min, at_max}); end
        cw = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_steps();
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 0, 0, 0, '0);
            checks++; if ($signed(position) !== k) begin failures++; $display("FAIL cw_step%0d got=%0d exp=%0d", k, $signed(position), k); end
            cyc(0, 0, 0, 0, '0);
            checks++; if ($signed(position) !== k) begin failures++; $display("FAIL cw_hold%0d got=%0d exp=%0d", k, $signed(position), k); end
        end
        for (int k = 1; k <= 2; k++) begin
            cyc(0, 1, 0, 0, '0);
            checks++; if ($signed(position) !== 5 - k) begin failures++; $display("FAIL ccw_step%0d got=%0d exp=%0d", k, $signed(position), 5 - k); end
            cyc(0, 0, 0, 0, '0);
        end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL steps_dir got=%b exp=0", dir); end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 0, 0, '0);
            checks++; if ($signed(position) !== 3 + k) begin failures++; $display("FAIL b2b_step%0d got=%0d exp=%0d", k, $signed(position), 3 + k); end
        end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL b2b_dir got=%b exp=1", dir); end
    endtask

    task automatic test_upper_limit();
        int hits = 0;
        cyc(0, 0, 0, 1, 16'd19999);
        checks++; if ($signed(position) !== 19999) begin failures++; $display("FAIL load_near_max got=%0d exp=19999", $signed(position)); end
        checks++; if ({at_max, limit_hit} !== 2'b00) begin failures++; $display("FAIL load_near_max_flags got=%b exp=00", {at_max, limit_hit}); end
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0, '0);
            hits += int'(limit_hit);
            checks++; if ($signed(position) !== 20000) begin failures++; $display("FAIL max_pos%0d got=%0d exp=20000", k, $signed(position)); end
            checks++; if (at_max !== 1'b1) begin failures++; $display("FAIL at_max%0d got=%b exp=1", k, at_max); end
            checks++; if (limit_hit !== (k != 0)) begin failures++; $display("FAIL max_hit%0d got=%b exp=%b", k, limit_hit, k != 0); end
        end
        cyc(0, 0, 0, 0, '0);
        checks++; if (limit_hit !== 1'b0) begin failures++; $display("FAIL max_hit_clear got=%b exp=0", limit_hit); end
        checks++; if (hits !== 2) begin failures++; $display("FAIL max_hit_count got=%0d exp=2", hits); end
    endtask

    task automatic test_lower_limit_and_clamp();
        cyc(0, 0, 0, 1, 16'd30000);
        checks++; if ($signed(position) !== 20000 || limit_hit !== 1'b0) begin failures++; $display("FAIL clamp_hi got=%0d/%b exp=20000/0", $signed(position), limit_hit); end
        cyc(0, 0, 0, 1, -16'sd30000);
        checks++; if ($signed(position) !== -20000 || at_min !== 1'b1) begin failures++; $display("FAIL clamp_lo got=%0d/%b exp=-20000/1", $signed(position), at_min); end
        cyc(0, 1, 0, 0, '0);
        checks++; if ($signed(position) !== -20000 || limit_hit !== 1'b1) begin failures++; $display("FAIL min_block got=%0d/%b exp=-20000/1", $signed(position), limit_hit); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL min_block_dir got=%b exp=1", dir); end
        cyc(1, 0, 0, 0, '0);
        checks++; if ($signed(position) !== -19999 || at_min !== 1'b0) begin failures++; $display("FAIL leave_min got=%0d/%b exp=-19999/0", $signed(position), at_min); end
    endtask

    task automatic test_priority();
        cyc(0, 1, 0, 0, '0);
        checks++; if ($signed(position) !== -20000 || dir !== 1'b0) begin failures++; $display("FAIL prio_setup got=%0d/%b exp=-20000/0", $signed(position), dir); end
        cyc(1, 0, 1, 1, 16'd100);
        checks++; if ($signed(position) !== 0) begin failures++; $display("FAIL zero_wins got=%0d exp=0", $signed(position)); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL zero_dir got=%b exp=0", dir); end
        cyc(1, 0, 0, 1, 16'd100);
        checks++; if ($signed(position) !== 100 || dir !== 1'b0) begin failures++; $display("FAIL load_wins got=%0d/%b exp=100/0", $signed(position), dir); end
    endtask

    task automatic test_conflict();
        cyc(1, 1, 0, 0, '0);
        checks++; if ($signed(position) !== 100) begin failures++; $display("FAIL conflict_pos got=%0d exp=100", $signed(position)); end
        checks++; if (conflict_err !== 1'b1 || dir !== 1'b0) begin failures++; $display("FAIL conflict_flag got=%b/%b exp=1/0", conflict_err, dir); end
        repeat (3) cyc(0, 0, 0, 0, '0);
        checks++; if (conflict_err !== 1'b1) begin failures++; $display("FAIL conflict_sticky got=%b exp=1", conflict_err); end
        do_reset();
        checks++; if (conflict_err !== 1'b0) begin failures++; $display("FAIL conflict_reset got=%b exp=0", conflict_err); end
    endtask

    task automatic test_velocity();
        logic [19:0] cw_pat  = 20'b0000_0000_0010_0001_0101;
        logic [19:0] ccw_pat = 20'b0000_1001_0000_0000_1000;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(cw_pat[i], ccw_pat[i], 0, 0, '0);
            if (i == 9) begin
                checks++; if ($signed(velocity) !== 3 || vel_valid !== 1'b1) begin failures++; $display("FAIL vel_win1 got=%0d/%b exp=3/1", $signed(velocity), vel_valid); end
            end else if (i == 19) begin
                checks++; if ($signed(velocity) !== -2 || vel_valid !== 1'b1) begin failures++; $display("FAIL vel_win2 got=%0d/%b exp=-2/1", $signed(velocity), vel_valid); end
            end else begin
                checks++; if (vel_valid !== 1'b0) begin failures++; $display("FAIL vel_valid_idle%0d got=%b exp=0", i, vel_valid); end
            end
        end
        checks++; if ($signed(position) !== 1) begin failures++; $display("FAIL vel_position got=%0d exp=1", $signed(position)); end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (19) cyc(0, 0, 0, 0, '0);
        checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL stall_early got=%b exp=0", stalled); end
        cyc(0, 0, 0, 0, '0);
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL stall_set got=%b exp=1", stalled); end
        repeat (3) cyc(0, 0, 0, 0, '0);
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL stall_hold got=%b exp=1", stalled); end
        cyc(1, 0, 0, 0, '0);
        checks++; if (stalled !== 1'b0 || $signed(position) !== 1) begin failures++; $display("FAIL stall_clear got=%b/%0d exp=0/1", stalled, $signed(position)); end
        cyc(0, 0, 0, 0, '0);
        checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL stall_restart got=%b exp=0", stalled); end
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, '0);
        cyc(1, 1, 0, 0, '0);
        checks++; if ($signed(position) !== 1 || dir !== 1'b0 || conflict_err !== 1'b1) begin failures++; $display("FAIL async_setup got=%0d/%b/%b exp=1/0/1", $signed(position), dir, conflict_err); end
        reset = 1'b1;
        #2;
        checks++; if (position !== 16'd0 || dir !== 1'b1 || conflict_err !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%b/%b exp=0/1/0", $signed(position), dir, conflict_err); end
        checks++; if ({vel_valid, limit_hit, stalled} !== 3'b000 || velocity !== 16'd0) begin failures++; $display("FAIL async_reset_flags got=%b/%0d exp=000/0", {vel_valid, limit_hit, stalled}, $signed(velocity)); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steps();
        test_back_to_back();
        test_upper_limit();
        test_lower_limit_and_clamp();
        test_priority();
        test_conflict();
        test_velocity();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
